gerenciador_medidas: RTL
========================

GERENCIADOR_MEDIDAS -- requirements
Module: gerenciador_medidas

Interface
REQ-001 Parameter PERIODO, default 5000000, clock cycles spent in ESPERA between measurements (100 ms at 50 MHz).
REQ-002 Parameter TIMEOUT, default 3000000, clock cycles allowed in AGUARDA for pronto (60 ms).
REQ-003 Parameter LIMIAR, default 12'h020, BCD proximity threshold in cm.
REQ-004 clock  in  1  system clock; one clock domain; all flops rising-edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 ligar  in  1  level enable for periodic measurement.
REQ-007 pronto  in  1  end-of-measurement pulse from the ultrasonic interface.
REQ-008 medida  in  12  3-digit BCD distance in cm from the ultrasonic interface.
REQ-009 medir  out  1  one-cycle start pulse to the ultrasonic interface.
REQ-010 distancia  out  12  median-filtered BCD distance, registered.
REQ-011 nova_medida  out  1  one-cycle pulse on each distancia update.
REQ-012 alarme  out  1  registered; 1 when distancia < LIMIAR.
REQ-013 erro_timeout  out  1  one-cycle pulse when TIMEOUT expires.
REQ-014 erro_bcd  out  1  one-cycle pulse when a sample contains a nibble > 9.
REQ-015 db_estado  out  4  current FSM state code.

Function
REQ-016 FSM states and codes: INICIAL 0, ESPERA 1, DISPARA 2, AGUARDA 3, ARMAZENA 4, ATUALIZA 5, ERRO F.
REQ-017 INICIAL: ligar=1 -> DISPARA next cycle; else stay; the first measurement incurs no PERIODO wait.
REQ-018 DISPARA: medir=1 for exactly this one cycle; timeout counter cleared; -> AGUARDA.
REQ-019 AGUARDA: pronto=1 -> ARMAZENA, medida captured on that same edge; timeout counter reaching TIMEOUT-1 without pronto -> ERRO; pronto and expiry on the same edge -> pronto wins.
REQ-020 pronto is ignored in every state other than AGUARDA.
REQ-021 ARMAZENA: any captured nibble > 9 -> erro_bcd pulse, sample discarded, -> ESPERA; else shift into 3-entry history (h0 newest), valid-count saturates at 3, -> ATUALIZA.
REQ-022 ATUALIZA: distancia <= h0 if valid-count is 1, min(h0,h1) if 2, median(h0,h1,h2) if 3; alarme updated from the new value; nova_medida=1; -> ESPERA.
REQ-023 distancia, alarme and nova_medida update on the edge exactly 2 cycles after the edge that samples pronto high.
REQ-024 BCD values are compared as plain 12-bit unsigned numbers (valid BCD preserves ordering); no BCD-to-binary conversion.
REQ-025 ERRO: erro_timeout=1 for this cycle; history and distancia unchanged; -> ESPERA.
REQ-026 ESPERA: interval counter runs 0..PERIODO-1, then -> DISPARA if ligar=1; ligar=0 at any cycle of ESPERA -> INICIAL immediately.
REQ-027 ligar deasserted in DISPARA, AGUARDA, ARMAZENA or ATUALIZA does not abort; the measurement completes and ESPERA then exits to INICIAL.
REQ-028 Interval and timeout counters clear on every entry to their state; no wrap-around is observable.
REQ-029 distancia, alarme and history hold their values in INICIAL and across ligar off/on; the history is cleared only by reset.

Reset
REQ-030 On reset: state INICIAL; medir, nova_medida, erro_timeout, erro_bcd, alarme = 0; distancia = 12'h000; history = 0; valid-count = 0; counters = 0; db_estado = 4'h0.
REQ-031 Reset asserted mid-measurement takes effect immediately, with no pending medir or nova_medida afterwards; on release the FSM restarts from REQ-017.

Structure
REQ-032 State codes and the default PERIODO, TIMEOUT and LIMIAR constants live in a shared package/header used by the bench.
REQ-033 One sub-module, contador_m (parameterised modulo-M counter with zera, conta, fim), is instantiated twice: interval and timeout.
REQ-034 The median/min selection is combinational logic inside the block; the FSM is implemented as a separate state register and next-state logic.

Verification (PERIODO=20, TIMEOUT=50, LIMIAR=12'h020)
REQ-035 Reset, then ligar=1 -> medir pulse 1 cycle later; pronto with medida=12'h045 10 cycles later -> distancia=12'h045, nova_medida 2 cycles after pronto, alarme=0.
REQ-036 Samples 045, 010, 300 -> distancia sequence 045, 010, 045; next sample 012 -> median(012,300,010)=012, alarme=1.
REQ-037 No pronto after medir -> erro_timeout pulse 50 cycles into AGUARDA, distancia unchanged, next medir after 20 ESPERA cycles.
REQ-038 medida=12'h0A5 with pronto -> erro_bcd pulse, no nova_medida, history and distancia unchanged.
REQ-039 ligar=0 during AGUARDA, then pronto -> distancia updated, FSM returns to INICIAL, no further medir; ligar=1 -> immediate medir.
REQ-040 Reset pulsed in AGUARDA -> all outputs 0 immediately; a late pronto is ignored; db_estado=0.

Source files
------------

// File: rtl/gerenciador_medidas_pkg.sv
// Shared definitions for the ultrasonic measurement manager: state codes,
// default timing constants and small BCD helpers.
package gerenciador_medidas_pkg;

    typedef enum logic [3:0] {
        INICIAL  = 4'h0,
        ESPERA   = 4'h1,
        DISPARA  = 4'h2,
        AGUARDA  = 4'h3,
        ARMAZENA = 4'h4,
        ATUALIZA = 4'h5,
        ERRO     = 4'hF
    } estado_t;

    localparam int          PERIODO_PADRAO = 5000000;
    localparam int          TIMEOUT_PADRAO = 3000000;
    localparam logic [11:0] LIMIAR_PADRAO  = 12'h020;

    function automatic logic bcd_valido(input logic [11:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
    endfunction

    // Valid BCD keeps numeric order, so plain unsigned compares are enough.
    function automatic logic [11:0] menor(input logic [11:0] a, input logic [11:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [11:0] maior(input logic [11:0] a, input logic [11:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [11:0] mediana3(input logic [11:0] a, input logic [11:0] b,
                                             input logic [11:0] c);
        return maior(menor(a, b), menor(maior(a, b), c));
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter: zera clears, conta advances, fim flags the last count (M-1).
module contador_m #(
    parameter int M = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);
    localparam int W = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0] valor;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            valor <= '0;
        else if (zera)
            valor <= '0;
        else if (conta)
            valor <= fim ? '0 : valor + 1'b1;
    end

    assign fim = (valor == W'(M - 1));

endmodule

// File: rtl/gerenciador_medidas.sv
// Periodically triggers an ultrasonic measurement, median-filters the last
// three valid BCD samples and flags proximity, timeout and BCD errors.
module gerenciador_medidas
    import gerenciador_medidas_pkg::*;
#(
    parameter int          PERIODO = PERIODO_PADRAO,
    parameter int          TIMEOUT = TIMEOUT_PADRAO,
    parameter logic [11:0] LIMIAR  = LIMIAR_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        pronto,
    input  logic [11:0] medida,
    output logic        medir,
    output logic [11:0] distancia,
    output logic        nova_medida,
    output logic        alarme,
    output logic        erro_timeout,
    output logic        erro_bcd,
    output logic [3:0]  db_estado
);
    estado_t     estado, prox;
    logic        fim_intervalo, fim_timeout;
    logic [11:0] amostra, h0, h1, h2, selecao;
    logic [1:0]  validas;

    // Both counters sit at zero outside their own state, so every entry starts clean.
    contador_m #(.M(PERIODO)) u_intervalo (
        .clock (clock),
        .reset (reset),
        .zera  (estado != ESPERA),
        .conta (estado == ESPERA),
        .fim   (fim_intervalo)
    );

    contador_m #(.M(TIMEOUT)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (estado != AGUARDA),
        .conta (estado == AGUARDA),
        .fim   (fim_timeout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            estado <= INICIAL;
        else
            estado <= prox;
    end

    // NOTE: prox gets a default before the case so no latch is inferred.
    always_comb begin
        prox = estado;
        case (estado)
            INICIAL:  if (ligar) prox = DISPARA;
            ESPERA:   if (!ligar) prox = INICIAL;
                      else if (fim_intervalo) prox = DISPARA;
            DISPARA:  prox = AGUARDA;
            AGUARDA:  if (pronto) prox = ARMAZENA;
                      else if (fim_timeout) prox = ERRO;
            ARMAZENA: prox = bcd_valido(amostra) ? ATUALIZA : ESPERA;
            ATUALIZA: prox = ESPERA;
            ERRO:     prox = ESPERA;
            default:  prox = INICIAL;
        endcase
    end

    always_comb begin
        selecao = h0;
        case (validas)
            2'd2:    selecao = menor(h0, h1);
            2'd3:    selecao = mediana3(h0, h1, h2);
            default: selecao = h0;
        endcase
    end

    // NOTE: the small history is explicitly reset; it is never cleared any other way.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            medir        <= 1'b0;
            nova_medida  <= 1'b0;
            erro_timeout <= 1'b0;
            erro_bcd     <= 1'b0;
            alarme       <= 1'b0;
            distancia    <= 12'h000;
            amostra      <= 12'h000;
            h0           <= 12'h000;
            h1           <= 12'h000;
            h2           <= 12'h000;
            validas      <= 2'd0;
        end else begin
            medir        <= (prox == DISPARA);
            erro_timeout <= (prox == ERRO);
            nova_medida  <= 1'b0;
            erro_bcd     <= 1'b0;
            if (estado == AGUARDA && pronto)
                amostra <= medida;
            if (estado == ARMAZENA) begin
                if (bcd_valido(amostra)) begin
                    h0 <= amostra;
                    h1 <= h0;
                    h2 <= h1;
                    if (validas != 2'd3)
                        validas <= validas + 2'd1;
                end else begin
                    erro_bcd <= 1'b1;
                end
            end
            if (estado == ATUALIZA) begin
                distancia   <= selecao;
                alarme      <= (selecao < LIMIAR);
                nova_medida <= 1'b1;
            end
        end
    end

    assign db_estado = estado;

endmodule
